// File: rtl/regfile_stream_server_if.sv
// Coefficient-stream bus between the CPU datapath / host (master) and the
// polynomial register file server (slave).
interface regfile_stream_server_if #(
    parameter int NREG = 8,
    parameter int N    = 16,
    parameter int W    = 32
);
    localparam int IW = $clog2(NREG);
    localparam int AW = $clog2(N);

    logic          start_operation;
    logic [IW-1:0] source0_register_index;
    logic [IW-1:0] source1_register_index;
    logic [IW-1:0] dest0_register_index;
    logic          register_file_ready;
    logic          source0_valid;
    logic          source1_valid;
    logic [W-1:0]  source0_coefficient;
    logic [W-1:0]  source1_coefficient;
    logic          source0_last;
    logic          source1_last;
    logic          dest0_valid;
    logic [W-1:0]  dest0_coefficient;
    logic          dest0_last;
    logic          load_valid;
    logic [IW-1:0] load_index;
    logic [AW-1:0] load_addr;
    logic [W-1:0]  load_data;
    logic          wb_error;

    modport master (
        output start_operation, source0_register_index, source1_register_index,
               dest0_register_index, dest0_valid, dest0_coefficient, dest0_last,
               load_valid, load_index, load_addr, load_data,
        input  register_file_ready, source0_valid, source1_valid,
               source0_coefficient, source1_coefficient, source0_last,
               source1_last, wb_error
    );

    modport slave (
        input  start_operation, source0_register_index, source1_register_index,
               dest0_register_index, dest0_valid, dest0_coefficient, dest0_last,
               load_valid, load_index, load_addr, load_data,
        output register_file_ready, source0_valid, source1_valid,
               source0_coefficient, source1_coefficient, source0_last,
               source1_last, wb_error
    );
endinterface

// File: rtl/regfile_stream_server.sv
// Polynomial register file: streams two source registers per operation and
// absorbs one lagging write-back stream; host preload port while idle.
module regfile_stream_server #(
    parameter int NREG = 8,
    parameter int N    = 16,
    parameter int W    = 32
) (
    input logic                    clk,
    input logic                    reset,
    regfile_stream_server_if.slave bus
);
    localparam int IW = $clog2(NREG);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST_BEAT = AW'(N - 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_WB} state_t;

    state_t        state, state_next;
    logic [W-1:0]  mem [NREG][N];

    logic [IW-1:0] src0_idx, src1_idx, dst_idx;
    logic [AW-1:0] rd_cnt, wr_cnt, rd_next;
    logic          wb_done, wb_error;
    logic          src_valid, src_last;
    logic [W-1:0]  src0_coef, src1_coef;
    logic [W-1:0]  beat0_s0, beat0_s1;

    logic          idle, start, wb_accept, wb_final, stream_end;

    logic          mem_we;
    logic [IW-1:0] mem_widx;
    logic [AW-1:0] mem_waddr;
    logic [W-1:0]  mem_wdata;

    assign idle       = (state == IDLE);
    assign start      = idle && bus.start_operation;
    assign wb_accept  = !idle && bus.dest0_valid;
    assign wb_final   = wb_accept && bus.dest0_last;
    assign stream_end = (state == STREAM) && (rd_cnt == LAST_BEAT);
    assign rd_next    = rd_cnt + 1'b1;

    // Beat 0 is read at the start edge, so a same-cycle host load must be forwarded.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        beat0_s0 = mem[bus.source0_register_index][0];
        beat0_s1 = mem[bus.source1_register_index][0];
        if (bus.load_valid && bus.load_addr == '0) begin
            if (bus.load_index == bus.source0_register_index) beat0_s0 = bus.load_data;
            if (bus.load_index == bus.source1_register_index) beat0_s1 = bus.load_data;
        end
    end

    // Host loads only while idle, write-back only while busy: never both.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = bus.load_index;
        mem_waddr = bus.load_addr;
        mem_wdata = bus.load_data;
        if (idle && bus.load_valid) begin
            mem_we = 1'b1;
        end else if (wb_accept) begin
            mem_we    = 1'b1;
            mem_widx  = dst_idx;
            mem_waddr = wr_cnt;
            mem_wdata = bus.dest0_coefficient;
        end
    end

    // NOTE: the storage array has no reset; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx][mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (stream_end) state_next = (wb_done || wb_final) ? IDLE : WAIT_WB;
            WAIT_WB: if (wb_final) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src0_idx  <= '0;
            src1_idx  <= '0;
            dst_idx   <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            wb_done   <= 1'b0;
            wb_error  <= 1'b0;
            src_valid <= 1'b0;
            src_last  <= 1'b0;
            src0_coef <= '0;
            src1_coef <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src0_idx  <= bus.source0_register_index;
                        src1_idx  <= bus.source1_register_index;
                        dst_idx   <= bus.dest0_register_index;
                        rd_cnt    <= '0;
                        wr_cnt    <= '0;
                        wb_done   <= 1'b0;
                        src_valid <= 1'b1;
                        src_last  <= 1'b0;
                        src0_coef <= beat0_s0;
                        src1_coef <= beat0_s1;
                    end
                end
                STREAM: begin
                    if (stream_end) begin
                        src_valid <= 1'b0;
                        src_last  <= 1'b0;
                        src0_coef <= '0;
                        src1_coef <= '0;
                    end else begin
                        rd_cnt    <= rd_next;
                        src_last  <= (rd_next == LAST_BEAT);
                        src0_coef <= mem[src0_idx][rd_next];
                        src1_coef <= mem[src1_idx][rd_next];
                    end
                end
                default: ;
            endcase

            if (wb_accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (bus.dest0_last) begin
                    wb_done <= 1'b1;
                    if (wr_cnt != LAST_BEAT) wb_error <= 1'b1;
                end else if (wr_cnt == LAST_BEAT) begin
                    wb_error <= 1'b1;
                end
            end
        end
    end

    assign bus.register_file_ready = idle;
    assign bus.source0_valid       = src_valid;
    assign bus.source1_valid       = src_valid;
    assign bus.source0_last        = src_last;
    assign bus.source1_last        = src_last;
    assign bus.source0_coefficient = src0_coef;
    assign bus.source1_coefficient = src1_coef;
    assign bus.wb_error            = wb_error;
endmodule
